// File: rtl/div_seq.sv
// Multi-cycle restoring divider for the ALU divide path: quotient to qLOW, remainder to rHI.
// Start/busy/done handshake; signed mode truncates toward zero, remainder follows the dividend's sign.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] qLOW,
  output logic [WIDTH-1:0] rHI,
  output logic             busy,
  output logic             done,
  output logic             dz
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_ITER  = 3'd2,
    S_FIX   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sgn_q, sgn_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             zdiv_q, zdiv_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_out_q, q_out_d;
  logic [WIDTH-1:0] r_out_q, r_out_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] trial;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    zdiv_d  = zdiv_q;
    cnt_d   = cnt_q;
    q_out_d = q_out_q;
    r_out_d = r_out_q;
    dz_d    = dz_q;

    // One extra bit on the trial subtract keeps the borrow unambiguous for full-range unsigned divisors.
    rem_sh = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    trial  = {1'b0, rem_sh} - {2'b00, dvs_q};

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          a_d     = A;
          b_d     = B;
          sgn_d   = sgn;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        qneg_d  = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        rneg_d  = sgn_q & a_q[WIDTH-1];
        quo_d   = (sgn_q && a_q[WIDTH-1]) ? -a_q : a_q;
        dvs_d   = (sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;
        rem_d   = '0;
        cnt_d   = '0;
        zdiv_d  = (b_q == '0);
        // A zero divisor skips the iterations but still passes through FIX to load the flagged result.
        state_d = (b_q == '0) ? S_FIX : S_ITER;
      end
      S_ITER: begin
        if (!trial[WIDTH+1]) begin
          rem_d = trial[WIDTH:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh;
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (zdiv_q) begin
          q_out_d = '1;
          r_out_d = a_q;
          dz_d    = 1'b1;
        end else begin
          q_out_d = qneg_q ? -quo_q : quo_q;
          r_out_d = rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
          dz_d    = 1'b0;
        end
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      zdiv_q  <= 1'b0;
      cnt_q   <= '0;
      q_out_q <= '0;
      r_out_q <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      zdiv_q  <= zdiv_d;
      cnt_q   <= cnt_d;
      q_out_q <= q_out_d;
      r_out_q <= r_out_d;
      dz_q    <= dz_d;
    end
  end

  assign qLOW = q_out_q;
  assign rHI  = r_out_q;
  assign dz   = dz_q;
  assign busy = (state_q == S_SETUP) || (state_q == S_ITER) || (state_q == S_FIX);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed divides with a scoreboard of expected results,
// latency and busy-cycle counts, ignored mid-operation start, and abort by reset.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic        sgn = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [31:0] qLOW, rHI;
  logic        busy, done, dz;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;
  int   busy_cnt = 0;

  div_seq #(.WIDTH(32)) dut (
    .clk(clk), .clr(clr), .start(start), .sgn(sgn), .A(A), .B(B),
    .qLOW(qLOW), .rHI(rHI), .busy(busy), .done(done), .dz(dz)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, sampling on the following falling edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      edge_cnt++;
      if (busy === 1'b1) busy_cnt++;
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t e;
    int sa, sb_v;
    sa = a;
    sb_v = b;
    e.dz = 1'b0;
    e.lat = 35;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = a;
      e.dz = 1'b1;
      e.lat = 3;
    end else if (!s) begin
      e.q = a / b;
      e.r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000;
      e.r = 32'd0;
    end else begin
      e.q = sa / sb_v;
      e.r = sa % sb_v;
    end
    return e;
  endfunction

  // Drive one start pulse; the start-sampling edge is counted as edge 1.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s, input bit push);
    if (push) sb.push_back(model(a, b, s));
    A = a;
    B = b;
    sgn = s;
    start = 1'b1;
    edge_cnt = 0;
    busy_cnt = 0;
    step(1);
    start = 1'b0;
    checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic waitResult(input string tag);
    exp_t e;
    logic [31:0] q_hold;
    while (done !== 1'b1 && edge_cnt < 200) step(1);
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd1);
    e = sb.pop_front();
    checkOutput({tag, "_latency"}, edge_cnt, e.lat);
    checkOutput({tag, "_busy_cycles"}, busy_cnt, e.lat - 1);
    checkOutput({tag, "_q"}, qLOW, e.q);
    checkOutput({tag, "_r"}, rHI, e.r);
    checkOutput({tag, "_dz"}, {31'd0, dz}, {31'd0, e.dz});
    q_hold = qLOW;
    step(1);
    checkOutput({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    checkOutput({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_q_hold"}, qLOW, q_hold);
  endtask

  initial begin
    clr = 1'b0;
    step(3);
    clr = 1'b1;
    step(1);
    checkOutput("reset_q", qLOW, 32'd0);
    checkOutput("reset_r", rHI, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_dz", {31'd0, dz}, 32'd0);

    applyStimulus(32'd100, 32'd7, 1'b1, 1);
    waitResult("s_100_7");
    applyStimulus(32'hFFFF_FF9C, 32'd7, 1'b1, 1);
    waitResult("s_m100_7");
    applyStimulus(32'd100, 32'hFFFF_FFF9, 1'b1, 1);
    waitResult("s_100_m7");
    applyStimulus(32'hFFFF_FFFF, 32'd2, 1'b0, 1);
    waitResult("u_ffff_2");
    applyStimulus(32'hFFFF_FFFF, 32'd2, 1'b1, 1);
    waitResult("s_m1_2");
    applyStimulus(32'd5, 32'd0, 1'b0, 1);
    waitResult("dz_5_0");
    applyStimulus(32'd9, 32'd3, 1'b0, 1);
    waitResult("u_9_3");
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1);
    waitResult("s_ovf");
    applyStimulus(32'hDEAD_BEEF, 32'h0001_2345, 1'b0, 1);
    waitResult("u_beef");

    // Start pulsed at iteration 5 with new operands must not disturb the running divide.
    applyStimulus(32'd100, 32'd7, 1'b1, 1);
    step(6);
    A = 32'd9;
    B = 32'd3;
    sgn = 1'b0;
    start = 1'b1;
    step(1);
    start = 1'b0;
    waitResult("ignored_start");

    // Reset mid-divide aborts it and clears every output.
    applyStimulus(32'd1000, 32'd13, 1'b0, 0);
    step(10);
    clr = 1'b0;
    step(1);
    clr = 1'b1;
    checkOutput("abort_q", qLOW, 32'd0);
    checkOutput("abort_r", rHI, 32'd0);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    step(3);
    checkOutput("abort_stays_idle", {31'd0, done | busy}, 32'd0);
    applyStimulus(32'd9, 32'd3, 1'b1, 1);
    waitResult("post_abort_9_3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
